// File: rtl/uart_alu_pkg.sv
// Shared constants and state encodings for the serial ALU.
`timescale 1ns/1ps
package uart_alu_pkg;
  localparam int DATA_W       = 8;
  localparam int OVERSAMPLING = 16;

  localparam logic [7:0] OP_ADD = 8'h20;
  localparam logic [7:0] OP_SUB = 8'h22;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SRA = 8'h03;
  localparam logic [7:0] OP_SRL = 8'h02;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {COL_WAIT_A, COL_WAIT_B, COL_WAIT_OP, COL_SEND} col_state_t;
endpackage

// File: rtl/uart_alu_rx.sv
// 8N1 UART receiver: two-flop synchroniser plus oversampled framing FSM.
`timescale 1ns/1ps
module uart_rx #(
  parameter int SAMPLES = uart_alu_pkg::OVERSAMPLING,
  parameter int WIDTH   = uart_alu_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_data,
  output logic             o_done
);
  import uart_alu_pkg::*;

  localparam int CW = $clog2(SAMPLES);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] MID  = CW'(SAMPLES/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES - 1);

  logic             rx_meta_q, rx_sync_q;
  rx_state_t        state_q, state_d;
  logic [CW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    case (state_q)
      RX_IDLE: if (!rx_sync_q) begin
        state_d    = RX_START;
        tick_cnt_d = '0;
      end
      // Mid-start re-check rejects short low glitches on the line.
      RX_START: if (i_tick) begin
        if (tick_cnt_q == MID) begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = rx_sync_q ? RX_IDLE : RX_DATA;
        end else tick_cnt_d = tick_cnt_q + 1'b1;
      end
      RX_DATA: if (i_tick) begin
        if (tick_cnt_q == LAST) begin
          tick_cnt_d = '0;
          shift_d    = {rx_sync_q, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == BW'(WIDTH-1)) state_d = RX_STOP;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end else tick_cnt_d = tick_cnt_q + 1'b1;
      end
      RX_STOP: if (i_tick) begin
        if (tick_cnt_q == LAST) begin
          state_d = RX_IDLE;
          done_d  = rx_sync_q;
        end else tick_cnt_d = tick_cnt_q + 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_data = shift_q;
  assign o_done = done_q;
endmodule

// File: rtl/uart_alu_top.sv
// Serial ALU: receives A, B, OPCODE over UART and replies with the 8-bit result.
`timescale 1ns/1ps
module uart_alu_top #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 38400,
  parameter int OVERSAMPLING = uart_alu_pkg::OVERSAMPLING,
  parameter int DATA_W       = uart_alu_pkg::DATA_W
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_tx
);
  import uart_alu_pkg::*;

  localparam int DIV  = (CLK_FREQ + (BAUD_RATE*OVERSAMPLING)/2) / (BAUD_RATE*OVERSAMPLING);
  localparam int DCW  = $clog2(DIV + 1);
  localparam int CW   = $clog2(OVERSAMPLING);
  localparam int BW   = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);

  // Oversampling tick generator
  logic [DCW-1:0] div_cnt_q, div_cnt_d;
  logic           tick;

  assign tick = (div_cnt_q == DCW'(DIV - 1));
  always_comb div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

  logic [DATA_W-1:0] rx_data;
  logic              rx_done;

  uart_rx #(.SAMPLES(OVERSAMPLING), .WIDTH(DATA_W)) u_rx (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .i_rx   (i_rx),
    .i_tick (tick),
    .o_data (rx_data),
    .o_done (rx_done)
  );

  // ALU: opcode is the byte arriving right now, operands are the stored A/B
  logic [7:0]        op;
  logic [BW-1:0]     shamt;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_res;

  assign op    = rx_data[7:0];
  assign shamt = b_q[BW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = a_q + b_q;
      OP_SUB: alu_res = a_q - b_q;
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_SRA: alu_res = DATA_W'($signed(a_q) >>> shamt);
      OP_SRL: alu_res = a_q >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Collector
  col_state_t        col_q, col_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              tx_start_q, tx_start_d;
  logic              tx_done;

  always_comb begin
    col_d      = col_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    tx_start_d = 1'b0;
    case (col_q)
      COL_WAIT_A:  if (rx_done) begin a_d = rx_data; col_d = COL_WAIT_B; end
      COL_WAIT_B:  if (rx_done) begin b_d = rx_data; col_d = COL_WAIT_OP; end
      COL_WAIT_OP: if (rx_done) begin
        res_d      = alu_res;
        tx_start_d = 1'b1;
        col_d      = COL_SEND;
      end
      COL_SEND:    if (tx_done) col_d = COL_WAIT_A;
      default:     col_d = COL_WAIT_A;
    endcase
  end

  // Transmitter; a start request waits for the next tick boundary
  tx_state_t         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_pend_q, tx_pend_d;
  logic              tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pend_d  = tx_pend_q;
    tx_d       = tx_q;
    tx_done    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_start_q) tx_pend_d = 1'b1;
        if (tx_pend_q && tick) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = res_q;
          tx_pend_d  = 1'b0;
          tx_d       = 1'b0;
        end
      end
      TX_START: if (tick) begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BW'(DATA_W-1)) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = TX_IDLE;
          tx_done    = 1'b1;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      div_cnt_q  <= '0;
      col_q      <= COL_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      tx_start_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_pend_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      col_q      <= col_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      tx_start_q <= tx_start_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_pend_q  <= tx_pend_d;
      tx_q       <= tx_d;
    end
  end

  assign o_tx = tx_q;
endmodule

// File: tb/tb_uart_alu_top.sv
// Scoreboard bench: stimulus pushes expected replies, a UART monitor decodes o_tx and checks them.
`timescale 1ns/1ps
module tb_uart_alu_top;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 25_000;
  localparam int OS       = 16;
  localparam int DIV      = 4;
  localparam int BIT      = OS * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic o_tx;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  bit frame_abort = 1'b0;

  uart_alu_top #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLING(OS), .DATA_W(8)) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .i_rx   (rx),
    .o_tx   (o_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0; idle(BIT);
    for (int i = 0; i < 8; i++) begin rx = d[i]; idle(BIT); end
    if (stop_ok) begin rx = 1'b1; idle(BIT); end
    else begin rx = 1'b0; idle(BIT*3/4); rx = 1'b1; idle(2*BIT); end
    idle(BIT/4);
  endtask

  task automatic wait_reply(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 48*BIT) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: reply timeout, %0d pending expected 0", name, sb.size());
      sb.delete();
    end
    idle(2*BIT);
  endtask

  task automatic triple(input string name, input logic [7:0] a, b, op, exp);
    sb.push_back(exp);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    send_byte(op, 1'b1);
    wait_reply(name);
  endtask

  // Monitor: decode each frame on o_tx at mid-bit and compare with the scoreboard
  initial begin
    logic [7:0] d;
    logic st, sp;
    forever begin
      @(negedge clk);
      if (rst_n && o_tx === 1'b0) begin
        idle(BIT/2);
        st = o_tx;
        for (int i = 0; i < 8; i++) begin idle(BIT); d[i] = o_tx; end
        idle(BIT);
        sp = o_tx;
        if (frame_abort) frame_abort = 1'b0;
        else if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got 0x%02h expected no frame", d);
        end else begin
          chk("start_bit", {7'd0, st}, 8'h00);
          chk("reply", d, sb.pop_front());
          chk("stop_bit", {7'd0, sp}, 8'h01);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    // Reset: line stays idle during and after reset
    bad = 0;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1 if (o_tx !== 1'b1) bad++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (o_tx !== 1'b1) bad++; end
    chk("reset_idle_bad_cycles", 8'(bad), 8'h00);

    triple("add",  8'h47, 8'h03, 8'h20, 8'h4A);
    triple("sub",  8'h03, 8'h05, 8'h22, 8'hFE);
    triple("nor",  8'hF0, 8'h3C, 8'h27, 8'h03);
    triple("sra",  8'h80, 8'h02, 8'h03, 8'hE0);
    triple("srl",  8'h80, 8'h02, 8'h02, 8'h20);
    triple("sra_mask", 8'h70, 8'h0B, 8'h03, 8'h0E);

    // Short low pulse must not register as a byte
    @(negedge clk); rx = 1'b0; idle(3*DIV); rx = 1'b1; idle(2*BIT);
    triple("and_after_glitch", 8'h0F, 8'h33, 8'h24, 8'h03);
    triple("or",   8'h0F, 8'h33, 8'h25, 8'h3F);
    triple("xor",  8'h0F, 8'h33, 8'h26, 8'h3C);
    triple("bad_op", 8'h0F, 8'h33, 8'h99, 8'h00);

    // Framing error on B: byte dropped, collector still waits for B
    sb.push_back(8'h32);
    send_byte(8'h10, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h20, 1'b1);
    wait_reply("framing_err");

    // Reset in the middle of a reply frame
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    n = 0;
    while (o_tx !== 1'b0 && n < 4*BIT) begin @(negedge clk); n++; end
    chk("abort_frame_started", {7'd0, o_tx}, 8'h00);
    idle(3*BIT + BIT/2);
    chk("pre_reset_tx", {7'd0, o_tx}, 8'h00);
    frame_abort = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1 chk("reset_mid_tx", {7'd0, o_tx}, 8'h01);
    @(negedge clk); rst_n = 1'b1;
    idle(12*BIT);
    triple("after_reset", 8'h7F, 8'h01, 8'h20, 8'h80);

    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
